// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and field helpers for the fetch stage
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int IMM16_MSB  = 15;
    localparam int IMM16_LSB  = 0;
    localparam int JADDR_MSB  = 25;
    localparam int JADDR_LSB  = 0;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    function automatic logic [31:0] jump_addr(input logic [3:0] pc4_top, input logic [25:0] jaddr);
        return {pc4_top, jaddr, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// rtl/fetch_stage_next_pc_sel.sv - redirect decision and next-PC mux
module next_pc_sel
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] if_id_pc4,
    input  logic [31:0] if_id_instr,
    input  logic        if_id_valid,
    input  logic        dec_branch,
    input  logic        dec_zero,
    input  logic        dec_jump,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        unused_opcode;

    assign unused_opcode = ^if_id_instr[OPCODE_MSB:OPCODE_LSB];

    always_comb begin
        branch_target = if_id_pc4 + branch_offset(if_id_instr[IMM16_MSB:IMM16_LSB]);
        jump_target   = jump_addr(if_id_pc4[31:28], if_id_instr[JADDR_MSB:JADDR_LSB]);
        // Decode outputs are meaningless while IF/ID holds a bubble.
        redirect      = if_id_valid & (dec_jump | (dec_branch & dec_zero));
        next_pc       = pc + 32'd4;
        if (redirect) begin
            next_pc = dec_jump ? jump_target : branch_target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, IF/ID latch and fetch counter
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        dec_branch,
    input  logic        dec_zero,
    input  logic        dec_jump,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_stage: RESET_PC must be word aligned");
    end

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] next_pc;
    logic        redirect;

    next_pc_sel u_next_pc_sel (
        .pc          (pc_q),
        .if_id_pc4   (pc4_q),
        .if_id_instr (instr_q),
        .if_id_valid (valid_q),
        .dec_branch  (dec_branch),
        .dec_zero    (dec_zero),
        .dec_jump    (dec_jump),
        .next_pc     (next_pc),
        .redirect    (redirect)
    );

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        // A redirect squashes the wrong-path slot even when stalled.
        if (redirect) begin
            pc_d    = next_pc;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = next_pc;
            instr_d = imem_data;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'd0;
    logic        dec_branch = 1'b0;
    logic        dec_zero = 1'b0;
    logic        dec_jump = 1'b0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_ovr [logic [31:0]];
    logic [31:0] salt;

    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .dec_branch  (dec_branch),
        .dec_zero    (dec_zero),
        .dec_jump    (dec_jump),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic void model_reset();
        m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
    endfunction

    function automatic void model_step(input logic s, input logic br, input logic z, input logic j);
        logic [31:0] target;
        if (m_valid && (j || (br && z))) begin
            if (j) target = {m_pc4[31:28], m_instr[25:0], 2'b00};
            else   target = m_pc4 + 32'($signed(m_instr[15:0])) * 32'd4;
            m_pc = target; m_instr = 32'd0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = memword(m_pc);
            m_pc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
        end
    endfunction

    task automatic cycle(input logic s, input logic br, input logic z, input logic j);
        stall = s; dec_branch = br; dec_zero = z; dec_jump = j;
        imem_data = memword(imem_addr);
        model_step(s, br, z, j);
        @(posedge clk);
        #1;
        stall = 1'b0; dec_branch = 1'b0; dec_zero = 1'b0; dec_jump = 1'b0;
        imem_data = memword(imem_addr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        imem_data = memword(imem_addr);
    endtask

    task automatic test_reset();
        mem_ovr.delete();
        mem_ovr[32'd0] = 32'h2008_0005;
        mem_ovr[32'd4] = 32'h2009_0003;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, 32'd0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
        checks++; if (if_id_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'd0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", if_id_pc4); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
        @(negedge clk); #2;
        reset = 1'b0;
        model_reset();
        imem_data = memword(imem_addr);
    endtask

    task automatic test_sequential();
        cycle(0, 0, 0, 0);
        checks++; if (if_id_instr !== 32'h2008_0005) begin errors++; $display("FAIL seq1_instr got %h exp 20080005", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'd4) begin errors++; $display("FAIL seq1_pc4 got %h exp 4", if_id_pc4); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq1_valid got %b exp 1", if_id_valid); end
        cycle(0, 0, 0, 0);
        checks++; if (if_id_instr !== 32'h2009_0003) begin errors++; $display("FAIL seq2_instr got %h exp 20090003", if_id_instr); end
        checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL seq2_pc got %h exp 8", imem_addr); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL seq2_count got %0d exp 2", fetch_count); end
    endtask

    task automatic test_branch_taken();
        mem_ovr[32'd8] = 32'h1109_0003;
        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 0);
        checks++; if (imem_addr !== 32'd24) begin errors++; $display("FAIL br_pc got %h exp 18", imem_addr); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b exp 0", if_id_valid); end
        checks++; if (if_id_instr !== 32'd0) begin errors++; $display("FAIL br_instr got %h exp 0", if_id_instr); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL br_count got %0d exp 3", fetch_count); end
        cycle(0, 0, 0, 0);
        checks++; if (if_id_pc4 !== 32'd28) begin errors++; $display("FAIL br_after_pc4 got %h exp 1c", if_id_pc4); end
        checks++; if (if_id_instr !== memword(32'd24)) begin errors++; $display("FAIL br_after_instr got %h exp %h", if_id_instr, memword(32'd24)); end
    endtask

    task automatic test_branch_not_taken();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        checks++; if (imem_addr !== 32'd16) begin errors++; $display("FAIL bnt_pc1 got %h exp 10", imem_addr); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL bnt_valid got %b exp 1", if_id_valid); end
        cycle(0, 0, 0, 0);
        checks++; if (imem_addr !== 32'd20) begin errors++; $display("FAIL bnt_pc2 got %h exp 14", imem_addr); end
    endtask

    task automatic test_jump();
        mem_ovr[32'd12] = 32'h0800_0010;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL j_pc got %h exp 40", imem_addr); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL j_count got %0d exp 4", fetch_count); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL j_valid got %b exp 0", if_id_valid); end
        checks++; if (if_id_pc4 !== 32'd16) begin errors++; $display("FAIL j_pc4_hold got %h exp 10", if_id_pc4); end
        cycle(0, 0, 0, 0);
        checks++; if (if_id_pc4 !== 32'h44) begin errors++; $display("FAIL j_after_pc4 got %h exp 44", if_id_pc4); end
        checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL j_after_count got %0d exp 5", fetch_count); end
    endtask

    task automatic test_stall();
        logic [31:0] held_instr;
        mem_ovr.delete();
        mem_ovr[32'd16] = 32'h0800_0020;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        held_instr = memword(32'd12);
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 0, 0);
            checks++; if (imem_addr !== 32'd16) begin errors++; $display("FAIL st_pc got %h exp 10", imem_addr); end
            checks++; if (if_id_instr !== held_instr) begin errors++; $display("FAIL st_instr got %h exp %h", if_id_instr, held_instr); end
            checks++; if (if_id_pc4 !== 32'd16) begin errors++; $display("FAIL st_pc4 got %h exp 10", if_id_pc4); end
            checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL st_valid got %b exp 1", if_id_valid); end
            checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL st_count got %0d exp 4", fetch_count); end
        end
        cycle(0, 0, 0, 0);
        checks++; if (if_id_instr !== 32'h0800_0020) begin errors++; $display("FAIL st_resume_instr got %h exp 08000020", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'd20) begin errors++; $display("FAIL st_resume_pc4 got %h exp 14", if_id_pc4); end
        cycle(1, 0, 0, 1);
        checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL st_jump_pc got %h exp 80", imem_addr); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL st_jump_valid got %b exp 0", if_id_valid); end
        checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL st_jump_count got %0d exp 5", fetch_count); end
    endtask

    task automatic test_wrap();
        mem_ovr.delete();
        mem_ovr[32'd0] = 32'h1000_FFFE;
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got %h exp fffffffc", imem_addr); end
        cycle(0, 0, 0, 0);
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL wrap_pc got %h exp 0", imem_addr); end
        checks++; if (if_id_pc4 !== 32'd0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", if_id_pc4); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL wrap_count got %0d exp 2", fetch_count); end
    endtask

    task automatic test_async_reset();
        mem_ovr.delete();
        mem_ovr[32'd12] = 32'h0800_000F;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        checks++; if (imem_addr !== 32'h40 || if_id_valid !== 1'b1) begin errors++; $display("FAIL ar_setup got pc %h valid %b exp 40 1", imem_addr, if_id_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL ar_pc got %h exp 0", imem_addr); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", if_id_valid); end
        checks++; if (if_id_instr !== 32'd0) begin errors++; $display("FAIL ar_instr got %h exp 0", if_id_instr); end
        checks++; if (if_id_pc4 !== 32'd0) begin errors++; $display("FAIL ar_pc4 got %h exp 0", if_id_pc4); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", fetch_count); end
        @(negedge clk); #2;
        reset = 1'b0;
        model_reset();
        imem_data = memword(imem_addr);
    endtask

    task automatic test_random();
        logic s, br, z, j;
        mem_ovr.delete();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            br = $urandom_range(0, 1) == 1;
            z  = $urandom_range(0, 1) == 1;
            j  = ($urandom_range(0, 5) == 0);
            cycle(s, br, z, j);
            checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, imem_addr, m_pc); end
            checks++; if (if_id_instr !== m_instr) begin errors++; $display("FAIL rnd_instr cyc %0d got %h exp %h", i, if_id_instr, m_instr); end
            checks++; if (if_id_pc4 !== m_pc4) begin errors++; $display("FAIL rnd_pc4 cyc %0d got %h exp %h", i, if_id_pc4, m_pc4); end
            checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, if_id_valid, m_valid); end
            checks++; if (fetch_count !== m_cnt) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", i, fetch_count, m_cnt); end
        end
    endtask

    initial begin
        salt = $urandom;
        model_reset();
        test_reset();
        test_sequential();
        test_branch_taken();
        test_branch_not_taken();
        test_jump();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
